button_debounce: RTL

// Conditions the raw, asynchronous front-panel button before it reaches the
// LED/counter logic in the 50 MHz clk domain. Synchronises the pin, rejects

---
 rtl/button_debounce.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/button_debounce.sv
// Button conditioner: two-flop synchroniser, polarity fix, bounce rejection
// with a stability counter, and registered level / press / release /
// long-press outputs.
//
// Handshake note: this block has no valid/ready interface. Every output is a
// plain registered signal in the clk_i domain; the pulses are one cycle wide
// and carry no back-pressure.
//
// state_o is a debug view of the FSM:
//   0 = RELEASED, 1 = PRESS_WAIT, 2 = PRESSED, 3 = RELEASE_WAIT.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned LONG_CYCLES     = 50000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       button_i,
    output logic       pressed_o,
    output logic       press_pulse_o,
    output logic       release_pulse_o,
    output logic       long_press_pulse_o,
    output logic [1:0] state_o
);

    localparam int DEB_W  = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = (LONG_CYCLES == 0) ? 1 : $clog2(LONG_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam bit                LONG_EN   = (LONG_CYCLES != 0);

    // Pin level seen while the button is not pressed.
    localparam logic REL_LVL = ACTIVE_LOW;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic              sync1_q;
    logic              sync2_q;
    logic              btn_s;

    state_t            state_q, state_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              long_done_q, long_done_d;
    logic              long_fire;

    logic              pressed_q, pressed_d;
    logic              press_pulse_q, press_pulse_d;
    logic              release_pulse_q, release_pulse_d;
    logic              long_pulse_q, long_pulse_d;

    // Two-flop synchroniser; resets to the released pin level so that
    // leaving reset never looks like a press.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q <= REL_LVL;
            sync2_q <= REL_LVL;
        end else begin
            sync1_q <= button_i;
            sync2_q <= sync1_q;
        end
    end

    // Polarity fix: btn_s is 1 while the button is physically pressed.
    assign btn_s = sync2_q ^ ACTIVE_LOW;

    // FSM and counter registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= RELEASED;
            deb_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            long_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_done_q <= long_done_d;
        end
    end

    // Next-state logic: a change is accepted only after the synchronised
    // level has disagreed with the current level for DEBOUNCE_CYCLES cycles
    // in a WAIT state; any agreeing sample returns to the settled state.
    always_comb begin
        state_d    = state_q;
        deb_cnt_d  = deb_cnt_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            RELEASED: begin
                if (btn_s) begin
                    state_d   = PRESS_WAIT;
                    deb_cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d   = RELEASED;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d    = PRESSED;
                    deb_cnt_d  = '0;
                    hold_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_d   = RELEASE_WAIT;
                    deb_cnt_d = '0;
                end else if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            RELEASE_WAIT: begin
                // A bounce back to pressed keeps the hold time accumulated so far.
                if (btn_s) begin
                    state_d   = PRESSED;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = RELEASED;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            default: begin
                state_d   = RELEASED;
                deb_cnt_d = '0;
            end
        endcase
    end

    // Output decode from the next state so every output is a register;
    // the long-press flag stays set until the button is fully released.
    always_comb begin
        long_fire = LONG_EN && (state_q == PRESSED) &&
                    (hold_cnt_q == HOLD_LAST) && !long_done_q;

        long_done_d = long_done_q;
        if (state_d == RELEASED) begin
            long_done_d = 1'b0;
        end else if (long_fire) begin
            long_done_d = 1'b1;
        end

        pressed_d       = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
        press_pulse_d   = pressed_d && !pressed_q;
        release_pulse_d = !pressed_d && pressed_q;
        long_pulse_d    = long_fire;
    end

    // Registered outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            long_pulse_q    <= 1'b0;
        end else begin
            pressed_q       <= pressed_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            long_pulse_q    <= long_pulse_d;
        end
    end

    assign pressed_o          = pressed_q;
    assign press_pulse_o      = press_pulse_q;
    assign release_pulse_o    = release_pulse_q;
    assign long_press_pulse_o = long_pulse_q;
    assign state_o            = state_q;

endmodule
